// File: rtl/mips_mc_control_if.sv
// Control bus between the multicycle control FSM and the MIPS datapath.
// The master (the controller) reads the instruction fields and the zero flag and drives every enable and select.
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: Moore-decoded datapath controls,
// a retired-instruction counter and an illegal-instruction flag.
module mips_mc_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_mc_control_if.master    ctl,
    output logic                 illegal_op,
    output logic [3:0]           state,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state, next_state;
    logic   retire;
    logic   c_pc_en, c_i_or_d, c_mem_read, c_mem_write, c_ir_write;
    logic   c_reg_dst, c_mem_to_reg, c_reg_write, c_alu_src_a, c_illegal;
    logic [1:0] c_alu_src_b, c_pc_source;
    logic [2:0] c_alu_op, funct_alu_op;
    logic       funct_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        funct_ok     = 1'b1;
        funct_alu_op = ALU_ADD;
        case (ctl.funct)
            6'b100000: funct_alu_op = ALU_ADD;
            6'b100010: funct_alu_op = ALU_SUB;
            6'b100100: funct_alu_op = ALU_AND;
            6'b100101: funct_alu_op = ALU_OR;
            6'b101010: funct_alu_op = ALU_SLT;
            default:   funct_ok     = 1'b0;
        endcase
    end

    always_comb begin
        next_state   = S_FETCH;
        retire       = 1'b0;
        c_pc_en      = 1'b0;
        c_i_or_d     = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_ir_write   = 1'b0;
        c_reg_dst    = 1'b0;
        c_mem_to_reg = 1'b0;
        c_reg_write  = 1'b0;
        c_alu_src_a  = 1'b0;
        c_alu_src_b  = 2'b00;
        c_pc_source  = 2'b00;
        c_alu_op     = ALU_AND;
        c_illegal    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                c_mem_read  = 1'b1;
                c_ir_write  = 1'b1;
                c_alu_src_b = 2'b01;
                c_alu_op    = ALU_ADD;
                c_pc_en     = 1'b1;
                next_state  = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                c_alu_src_b = 2'b11;
                c_alu_op    = ALU_ADD;
                case (ctl.opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) next_state = S_RTYPE_EX;
                        else          c_illegal  = 1'b1;
                    end
                    OP_BEQ:  next_state = S_BEQ_EX;
                    OP_ADDI: next_state = S_ADDI_EX;
                    OP_J:    next_state = S_JUMP;
                    default: c_illegal  = 1'b1;
                endcase
            end
            S_MEMADR: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'b10;
                c_alu_op    = ALU_ADD;
                next_state  = (ctl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c_mem_read = 1'b1;
                c_i_or_d   = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                c_reg_write  = 1'b1;
                c_mem_to_reg = 1'b1;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                c_mem_write = 1'b1;
                c_i_or_d    = 1'b1;
                retire      = 1'b1;
            end
            S_RTYPE_EX: begin
                c_alu_src_a = 1'b1;
                c_alu_op    = funct_alu_op;
                next_state  = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                c_reg_write = 1'b1;
                c_reg_dst   = 1'b1;
                retire      = 1'b1;
            end
            S_BEQ_EX: begin
                c_alu_src_a = 1'b1;
                c_alu_op    = ALU_SUB;
                c_pc_source = 2'b01;
                c_pc_en     = ctl.zero;
                retire      = 1'b1;
            end
            S_JUMP: begin
                c_pc_source = 2'b10;
                c_pc_en     = 1'b1;
                retire      = 1'b1;
            end
            S_ADDI_EX: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'b10;
                c_alu_op    = ALU_ADD;
                next_state  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                c_reg_write = 1'b1;
                retire      = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Gating with rst_n drops every strobe the moment reset asserts, without waiting for a clock edge.
    assign ctl.pc_en      = rst_n & c_pc_en;
    assign ctl.i_or_d     = rst_n & c_i_or_d;
    assign ctl.mem_read   = rst_n & c_mem_read;
    assign ctl.mem_write  = rst_n & c_mem_write;
    assign ctl.ir_write   = rst_n & c_ir_write;
    assign ctl.reg_dst    = rst_n & c_reg_dst;
    assign ctl.mem_to_reg = rst_n & c_mem_to_reg;
    assign ctl.reg_write  = rst_n & c_reg_write;
    assign ctl.alu_src_a  = rst_n & c_alu_src_a;
    assign ctl.alu_src_b  = rst_n ? c_alu_src_b : 2'b00;
    assign ctl.pc_source  = rst_n ? c_pc_source : 2'b00;
    assign ctl.alu_op     = rst_n ? c_alu_op    : 3'b000;
    assign illegal_op     = rst_n & c_illegal;
    assign state          = cur_state;

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, plus the 3-bit ALU operation code consumed by the ALU.
- Also maintains a retired-instruction counter and an illegal-instruction flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26], stable from the cycle after FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, same cycle.
- pc_en  out  1  PC write enable (jump/fetch, or branch taken).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register select: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B select: 00=regB, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_op  out  3  ALU operation: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- illegal_op  out  1  unsupported instruction seen in DECODE.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Outputs are Moore-decoded from state. Exceptions: alu_op in RTYPE_EX depends on funct; pc_en in BEQ_EX equals zero.
- While rst_n=0: state=FETCH(0), retired=0, and every output is forced to 0 (including alu_op=000 and state=0). No strobe is asserted during reset.
- Reset asserted mid-instruction aborts it immediately. The first cycle after release is FETCH.
- Signals not listed for a state are 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_EX 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
- FETCH:
  - mem_read=1, ir_write=1, alu_src_b=01, alu_op=ADD, pc_en=1.
  - Next state: DECODE.
- DECODE:
  - alu_src_b=11, alu_op=ADD (precomputes the branch target).
  - Next state by opcode: 100011 lw and 101011 sw -> MEMADR; 000000 -> RTYPE_EX; 000100 beq -> BEQ_EX; 001000 addi -> ADDI_EX; 000010 j -> JUMP.
  - Illegal cases: any other opcode, or opcode 000000 with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}.
  - On an illegal case: illegal_op=1 for this single cycle, next state FETCH, retired unchanged.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Next state MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1. Retires. Next state FETCH.
- MEMWR: mem_write=1, i_or_d=1. Retires. Next state FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op from funct (add 010, sub 110, and 000, or 001, slt 111). Next state RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1. Retires. Next state FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_en=zero. Retires. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state ADDI_WB.
- ADDI_WB: reg_write=1. Retires. Next state FETCH.
- JUMP: pc_source=10, pc_en=1. Retires. Next state FETCH.
- Retired counter:
  - Increments by 1 on the rising edge leaving a retiring state.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Instruction latencies (cycles, FETCH to last state inclusive): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Only FETCH asserts ir_write, and alu_op is never driven to an undefined code. At most one of mem_read/mem_write is asserted in any cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with opcode=100011. Required: all outputs 0 during reset. State sequence 0,1,2,3,4,0. reg_write=mem_to_reg=1 only in state 4. retired=1 after the sequence.
- R-type: apply opcode=000000 with each of funct=100000/100010/100100/100101/101010. Required: alu_op in RTYPE_EX = 010/110/000/001/111 respectively. reg_dst=1 in RTYPE_WB. retired increments by 5 total.
- beq: run with zero=1, then with zero=0. Required: BEQ_EX pc_en=1 then 0. pc_source=01 and alu_op=110 both times. Each instruction takes 3 cycles.
- Illegal instructions: apply opcode=111111, then 000000 with funct=000000. Required: illegal_op=1 for exactly one cycle in DECODE, next state FETCH, retired unchanged.
- Reset mid-operation: de-assert rst_n asynchronously mid-cycle while in MEMRD. Required: mem_read and i_or_d drop to 0 without waiting for a clock edge. retired=0. The first post-release state is 0.
- Counter wrap: use CNT_W=4 and 16 back-to-back j instructions. Required: retired wraps 15 -> 0. pc_source=10 and pc_en=1 in every JUMP cycle.
